// File: rtl/sha256_pkg.sv
// SHA-256 shared constants, state encoding and bit-mixing helpers.
// Used by both the schedule expansion and the compression rounds.
package sha256_pkg;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_e;

  // Packed so that 'a' lands in [255:224], matching H0 in hash_in.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  function automatic logic [31:0] big_sigma0(
    input logic [31:0] x
  );
    return {x[1:0], x[31:2]}
         ^ {x[12:0], x[31:13]}
         ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(
    input logic [31:0] x
  );
    return {x[5:0], x[31:6]}
         ^ {x[10:0], x[31:11]}
         ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(
    input logic [31:0] x
  );
    return {x[6:0], x[31:7]}
         ^ {x[17:0], x[31:18]}
         ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(
    input logic [31:0] x
  );
    return {x[16:0], x[31:17]}
         ^ {x[18:0], x[31:19]}
         ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(
    input logic [31:0] e,
    input logic [31:0] f,
    input logic [31:0] g
  );
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c
  );
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_compress_rounds_if.sv
// Block request / digest return bundle between the schedule
// stage, the compression engine and the digest controller.
interface sha256_compress_rounds_if;
  logic          start;
  logic [2047:0] w_vector;
  logic [255:0]  hash_in;
  logic          busy;
  logic          done;
  logic [255:0]  hash_out;

  modport master (
    output start,
    output w_vector,
    output hash_in,
    input  busy,
    input  done,
    input  hash_out
  );

  modport slave (
    input  start,
    input  w_vector,
    input  hash_in,
    output busy,
    output done,
    output hash_out
  );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working vars in, next
// working vars out for the given K[t] and W[t].
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output work_t       nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = cur.h
       + big_sigma1(cur.e)
       + ch(cur.e, cur.f, cur.g)
       + k
       + w;
    t2 = big_sigma0(cur.a)
       + maj(cur.a, cur.b, cur.c);

    nxt   = cur;
    nxt.h = cur.g;
    nxt.g = cur.f;
    nxt.f = cur.e;
    nxt.e = cur.d + t1;
    nxt.d = cur.c;
    nxt.c = cur.b;
    nxt.b = cur.a;
    nxt.a = t1 + t2;
  end

endmodule

// File: rtl/sha256_compress_rounds.sv
// SHA-256 compression engine: 64 rounds at one round per clock,
// then a feed-forward add into the latched chaining value.
module sha256_compress_rounds
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic clock,
  input  logic reset,
  sha256_compress_rounds_if.slave bus
);

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  state_e         state_q, state_d;
  logic [5:0]     t_q, t_d;
  work_t          work_q, work_d;
  logic [2047:0]  w_q, w_d;
  logic [255:0]   h_q, h_d;
  logic [255:0]   hash_q, hash_d;
  logic           done_q, done_d;

  logic [31:0]    w_cur;
  logic [31:0]    k_cur;
  work_t          work_nxt;
  logic [255:0]   work_vec;
  logic [255:0]   sum;

  assign w_cur    = w_q[{t_q, 5'd0} +: 32];
  assign k_cur    = K[t_q];
  assign work_vec = work_q;

  sha256_round u_round (
    .cur (work_q),
    .k   (k_cur),
    .w   (w_cur),
    .nxt (work_nxt)
  );

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum[32*i +: 32] = h_q[32*i +: 32]
                      + work_vec[32*i +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    work_d  = work_q;
    w_d     = w_q;
    h_d     = h_q;
    hash_d  = hash_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ROUND;
          w_d     = bus.w_vector;
          h_d     = bus.hash_in;
          work_d  = work_t'(bus.hash_in);
          t_d     = '0;
        end
      end
      ROUND: begin
        work_d = work_nxt;
        t_d    = t_q + 6'd1;
        if (t_q == LAST_T) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        hash_d  = sum;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      work_q  <= '0;
      w_q     <= '0;
      h_q     <= '0;
      hash_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      work_q  <= work_d;
      w_q     <= w_d;
      h_q     <= h_d;
      hash_q  <= hash_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.hash_out = hash_q;

endmodule

// File: tb/tb_sha256_compress_rounds.sv
// Bench for sha256_compress_rounds: known digests, random blocks
// against a reference model, and reset/restart corner cases.
module tb_sha256_compress_rounds;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  sha256_compress_rounds_if bus();

  sha256_compress_rounds #(
    .NUM_ROUNDS (64)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] HINIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [511:0] M_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] M_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] M_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] M_TWO2  = {480'h0, 32'h000001c0};

  typedef struct {
    logic [511:0] msg;
    logic [255:0] hin;
    logic [255:0] exp;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full 64-word schedule, W[0] in the LSBs.
  function automatic logic [2047:0] expand(input logic [511:0] msg);
    logic [31:0]   w [64];
    logic [2047:0] v;
    for (int t = 0; t < 16; t++) w[t] = msg[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
           + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
           + w[t-16];
    end
    v = '0;
    for (int t = 0; t < 64; t++) v[32*t +: 32] = w[t];
    return v;
  endfunction

  function automatic logic [255:0] ref_compress(
    input logic [255:0]  hin,
    input logic [2047:0] wv
  );
    logic [31:0]  s [8];
    logic [31:0]  hw [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      hw[i] = hin[255 - 32*i -: 32];
      s[i]  = hw[i];
    end
    for (int t = 0; t < 64; t++) begin
      t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + wv[32*t +: 32];
      t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int i = 7; i > 0; i--) s[i] = s[i-1];
      s[4] = s[4] + t1;
      s[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hw[i] + s[i];
    return r;
  endfunction

  task automatic check(
    input string        name,
    input logic [255:0] act,
    input logic [255:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Waits for done after the accepting edge; n counts edges since E0.
  task automatic wait_done(output int n, output int overlap);
    n = 0;
    overlap = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (bus.busy && bus.done) overlap++;
    end while (!bus.done && n < 200);
  endtask

  task automatic run_block(
    input string        name,
    input logic [255:0] hin,
    input logic [511:0] msg,
    input logic [255:0] exp
  );
    int n, ov;
    logic [255:0] held;
    @(negedge clock);
    bus.hash_in  = hin;
    bus.w_vector = expand(msg);
    bus.start    = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    check({name, "_busy"}, 256'(bus.busy), 256'd1);
    wait_done(n, ov);
    check({name, "_latency"}, 256'(n), 256'd65);
    check({name, "_overlap"}, 256'(ov), 256'd0);
    check({name, "_hash"}, bus.hash_out, exp);
    held = bus.hash_out;
    @(posedge clock);
    #1;
    check({name, "_pulse"}, {254'd0, bus.done, bus.busy}, 256'd0);
    check({name, "_hold"}, bus.hash_out, held);
  endtask

  initial begin
    int n, ov, extra, d1, d2;
    logic [255:0] b1res, h1;
    logic [511:0] m;

    tbl[0] = '{M_ABC, HINIT, D_ABC};
    tbl[1] = '{M_EMPTY, HINIT, D_EMPTY};
    for (int i = 2; i < 6; i++) begin
      m = '0;
      for (int j = 0; j < 16; j++) m[32*j +: 32] = $urandom;
      tbl[i].msg = m;
      tbl[i].hin = '0;
      for (int j = 0; j < 8; j++) tbl[i].hin[32*j +: 32] = $urandom;
      tbl[i].exp = ref_compress(tbl[i].hin, expand(m));
    end

    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.w_vector = '0;
    bus.hash_in  = '0;
    #12;
    check("reset_hash", bus.hash_out, 256'd0);
    check("reset_ctrl", {254'd0, bus.done, bus.busy}, 256'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_block($sformatf("vec%0d", i), tbl[i].hin, tbl[i].msg, tbl[i].exp);
    end

    // start re-pulsed mid-block with scrambled inputs
    @(negedge clock);
    bus.hash_in  = HINIT;
    bus.w_vector = expand(M_ABC);
    bus.start    = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    n = 0;
    ov = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (bus.busy && bus.done) ov++;
      if (n == 30) begin
        bus.start = 1'b1;
        bus.hash_in = {8{$urandom}};
        bus.w_vector = {64{$urandom}};
      end else if (n == 31) begin
        bus.start = 1'b0;
      end
    end while (!bus.done && n < 200);
    check("midstart_latency", 256'(n), 256'd65);
    check("midstart_hash", bus.hash_out, D_ABC);
    check("midstart_overlap", 256'(ov), 256'd0);
    extra = 0;
    repeat (80) begin
      @(posedge clock);
      #1;
      if (bus.done) extra++;
    end
    check("midstart_no_second_done", 256'(extra), 256'd0);

    // asynchronous reset during round 40
    @(negedge clock);
    bus.hash_in  = HINIT;
    bus.w_vector = expand(M_ABC);
    bus.start    = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (41) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort_hash", bus.hash_out, 256'd0);
    check("abort_ctrl", {254'd0, bus.done, bus.busy}, 256'd0);
    @(negedge clock);
    reset = 1'b1;
    extra = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.busy) extra++;
    end
    check("abort_quiet", 256'(extra), 256'd0);
    run_block("after_abort", HINIT, M_ABC, D_ABC);

    // two blocks with start held high
    b1res = ref_compress(HINIT, expand(M_TWO1));
    @(negedge clock);
    bus.hash_in  = HINIT;
    bus.w_vector = expand(M_TWO1);
    bus.start    = 1'b1;
    @(posedge clock);
    #1;
    bus.hash_in  = b1res;
    bus.w_vector = expand(M_TWO2);
    n = 0;
    d1 = -1;
    d2 = -1;
    h1 = '0;
    ov = 0;
    while (n < 140) begin
      @(posedge clock);
      #1;
      n++;
      if (bus.busy && bus.done) ov++;
      if (bus.done && d1 < 0) begin
        d1 = n;
        h1 = bus.hash_out;
      end else if (bus.done && d2 < 0) begin
        d2 = n;
        bus.start = 1'b0;
        check("two_final_hash", bus.hash_out, D_TWO);
      end
      if (d1 >= 0 && n == d1 + 1) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    check("two_done1_cycle", 256'(d1), 256'd65);
    check("two_done2_cycle", 256'(d2), 256'd131);
    check("two_block1_hash", h1, b1res);
    check("two_overlap", 256'(ov), 256'd0);
    check("two_hold", bus.hash_out, D_TWO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
